// File: rtl/countdown_arbiter_ctrl.sv
// countdown_arbiter_ctrl: arbitrates B/V level requests for a shared
// BCD countdown, paces it from a prescaler, reports done and fault.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_b, req_v          level requests, held high for the whole service
//   error                 level fault input, beats requests
//   grant_b, grant_v      which side owns the timer
//   bcd[3:0]              current count, 0..9
//   busy, done, fault     RUN state, completion pulse, FAULT state
module countdown_arbiter_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int START_VAL = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_b,
  input  logic       req_v,
  input  logic       error,
  output logic       grant_b,
  output logic       grant_v,
  output logic [3:0] bcd,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam int PW = $clog2(TICK_DIV) + 1;
  localparam logic [PW-1:0] TLAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] SVAL = 4'(START_VAL);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DN,
    FLT
  } state_t;

  state_t        state;
  logic [PW-1:0] ps;
  logic          ptr_v;
  logic          side_v;
  logic          req_own;
  logic          tick;
  logic          pick_v;

  assign req_own = side_v ? req_v : req_b;
  assign tick    = (ps == TLAST);
  // V wins when it is the only requester, or both ask and V has the turn.
  assign pick_v  = req_v & (~req_b | ptr_v);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ps      <= '0;
      ptr_v   <= 1'b0;
      side_v  <= 1'b0;
      grant_b <= 1'b0;
      grant_v <= 1'b0;
      bcd     <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else if (error) begin
      state   <= FLT;
      ps      <= '0;
      grant_b <= 1'b0;
      grant_v <= 1'b0;
      bcd     <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          if (req_b | req_v) begin
            state   <= RUN;
            side_v  <= pick_v;
            grant_b <= ~pick_v;
            grant_v <= pick_v;
            busy    <= 1'b1;
            bcd     <= SVAL;
            ps      <= '0;
          end
        end
        RUN: begin
          if (!req_own) begin
            // Abandoned service: no done, pointer kept.
            state   <= IDLE;
            grant_b <= 1'b0;
            grant_v <= 1'b0;
            busy    <= 1'b0;
            bcd     <= 4'd0;
            ps      <= '0;
          end else if (tick) begin
            ps <= '0;
            if (bcd == 4'd0) begin
              state   <= DN;
              done    <= 1'b1;
              grant_b <= 1'b0;
              grant_v <= 1'b0;
              busy    <= 1'b0;
              ptr_v   <= ~side_v;
            end else begin
              bcd <= bcd - 4'd1;
            end
          end else begin
            ps <= ps + PW'(1);
          end
        end
        DN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        FLT: begin
          state <= IDLE;
          fault <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_arbiter_ctrl.sv
// tb_countdown_arbiter_ctrl: directed plus random stimulus on two
// instances (4/9 and 1/0) against an elapsed-time reference model.
module tb_countdown_arbiter_ctrl;

  logic clock = 1'b0;
  logic reset, req_b, req_v, error;

  logic       gb0, gv0, by0, dn0, ft0;
  logic [3:0] bc0;
  logic       gb1, gv1, by1, dn1, ft1;
  logic [3:0] bc1;

  int checks = 0;
  int errors = 0;

  int td[2] = '{4, 1};
  int sv[2] = '{9, 0};

  // model: mode 0 idle, 1 run, 2 done, 3 fault; t = cycles since RUN entry
  int m_mode[2];
  int m_t[2];
  bit m_ptr[2];
  bit m_side[2];

  always #5 clock = ~clock;

  countdown_arbiter_ctrl #(.TICK_DIV(4), .START_VAL(9)) u_dut (
    .clock(clock), .reset(reset), .req_b(req_b), .req_v(req_v),
    .error(error), .grant_b(gb0), .grant_v(gv0), .bcd(bc0),
    .busy(by0), .done(dn0), .fault(ft0)
  );

  countdown_arbiter_ctrl #(.TICK_DIV(1), .START_VAL(0)) u_min (
    .clock(clock), .reset(reset), .req_b(req_b), .req_v(req_v),
    .error(error), .grant_b(gb1), .grant_v(gv1), .bcd(bc1),
    .busy(by1), .done(dn1), .fault(ft1)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mstep(input int i);
    if (reset) begin
      m_mode[i] = 0;
      m_t[i] = 0;
      m_ptr[i] = 0;
      m_side[i] = 0;
    end else if (error) begin
      m_mode[i] = 3;
    end else begin
      case (m_mode[i])
        0: if (req_b | req_v) begin
          m_side[i] = req_v & (!req_b | m_ptr[i]);
          m_mode[i] = 1;
          m_t[i] = 0;
        end
        1: if (!(m_side[i] ? req_v : req_b)) begin
          m_mode[i] = 0;
        end else begin
          m_t[i]++;
          if (m_t[i] == (sv[i] + 1) * td[i]) begin
            m_mode[i] = 2;
            m_ptr[i] = !m_side[i];
          end
        end
        default: m_mode[i] = 0;
      endcase
    end
  endtask

  task automatic compare(input int i);
    logic [4:0] obs, exp;
    logic [3:0] ob, eb;
    bit run;
    if (i == 0) begin
      obs = {gb0, gv0, by0, dn0, ft0};
      ob = bc0;
    end else begin
      obs = {gb1, gv1, by1, dn1, ft1};
      ob = bc1;
    end
    run = (m_mode[i] == 1);
    exp = {run && !m_side[i], run && m_side[i], run,
           m_mode[i] == 2, m_mode[i] == 3};
    eb = run ? 4'(sv[i] - m_t[i] / td[i]) : 4'd0;
    chk(i == 0 ? "flags_a" : "flags_b", {3'b0, obs}, {3'b0, exp});
    chk(i == 0 ? "bcd_a" : "bcd_b", {4'b0, ob}, {4'b0, eb});
    chk(i == 0 ? "excl_a" : "excl_b", {7'b0, obs[4] & obs[3]}, 8'd0);
  endtask

  task automatic cyc(input bit rs, input bit rb, input bit rv,
                     input bit er);
    @(negedge clock);
    reset = rs;
    req_b = rb;
    req_v = rv;
    error = er;
    @(posedge clock);
    mstep(0);
    mstep(1);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic run(input int n, input bit rs, input bit rb,
                     input bit rv, input bit er);
    for (int k = 0; k < n; k++) cyc(rs, rb, rv, er);
  endtask

  initial begin
    bit rb, rv;
    int ecnt;
    reset = 1'b1;
    req_b = 1'b0;
    req_v = 1'b0;
    error = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0;
      m_t[i] = 0;
      m_ptr[i] = 0;
      m_side[i] = 0;
    end
    run(2, 1, 0, 0, 0);
    run(10, 0, 0, 0, 0);
    // single B service
    run(45, 0, 1, 0, 0);
    run(2, 0, 0, 0, 0);
    // both held: alternating services
    run(130, 0, 1, 1, 0);
    run(2, 0, 0, 0, 0);
    // fault mid-count, then recover and re-grant
    run(18, 0, 0, 1, 0);
    run(1, 0, 0, 1, 1);
    run(45, 0, 0, 1, 0);
    run(2, 0, 0, 0, 0);
    // V abandons mid-count, then both high
    run(28, 0, 0, 1, 0);
    run(1, 0, 0, 0, 0);
    run(50, 0, 1, 1, 0);
    // reset together with error mid-count
    run(1, 1, 0, 0, 0);
    run(14, 0, 1, 0, 0);
    run(1, 1, 1, 0, 1);
    run(5, 0, 0, 0, 0);
    // random phase
    rb = 0;
    rv = 0;
    ecnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) rb = !rb;
      if ($urandom_range(0, 59) == 0) rv = !rv;
      if (ecnt > 0) ecnt--;
      else if ($urandom_range(0, 199) == 0) ecnt = $urandom_range(1, 3);
      cyc($urandom_range(0, 499) == 0, rb, rv, ecnt > 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
